// File: rtl/sha256_sched_pkg.sv
// Shared definitions for the SHA-256 message-schedule blocks: FSM encoding,
// default padding/length words for a 256-bit second-pass message, sigma functions.
package sha256_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_EXPAND = 2'd2
  } sched_state_e;

  localparam logic [31:0] PAD_WORD_DEF = 32'h8000_0000;
  localparam logic [31:0] LEN_WORD_DEF = 32'h0000_0100;
  localparam int          WIN_WORDS    = 16;
  localparam logic [5:0]  T_EMIT_LAST  = 6'd15;
  localparam logic [5:0]  T_LAST       = 6'd63;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_step.sv
// One combinational SHA-256 schedule step: W[t] from the 16-word window,
// where i_win[0] is W[t-16] and i_win[15] is W[t-1].
module sha256_w_step
  import sha256_sched_pkg::*;
(
  input  logic [WIN_WORDS-1:0][31:0] i_win,
  output logic [31:0]                o_w
);

  assign o_w = sig1(i_win[14]) + i_win[9] + sig0(i_win[1]) + i_win[0];

endmodule

// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 schedule generator for the second hash pass: accepts a 256-bit digest,
// pads it into a single block and streams W[0..63] over a valid/ready handshake.
module sha256_w_sched_ctrl
  import sha256_sched_pkg::*;
#(
  parameter logic [31:0] LEN_WORD = LEN_WORD_DEF,
  parameter logic [31:0] PAD_WORD = PAD_WORD_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] digest_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   t_out,
  output logic         last,
  output logic         busy
);

  sched_state_e                r_state;
  sched_state_e                w_state_nxt;
  logic [5:0]                  r_t;
  logic [WIN_WORDS-1:0][31:0]  r_win;
  logic [WIN_WORDS-1:0][31:0]  w_win_init;
  logic [31:0]                 w_next_word;
  logic                        w_load;
  logic                        w_adv;
  logic                        w_shift;
  logic                        w_done;

  sha256_w_step u_step (
    .i_win (r_win),
    .o_w   (w_next_word)
  );

  // Padded block: digest words, the 0x80 pad bit, zero fill, then bit length.
  always_comb begin
    w_win_init = '0;
    for (int i = 0; i < 8; i++) begin
      w_win_init[i] = digest_in[255-32*i -: 32];
    end
    w_win_init[8]           = PAD_WORD;
    w_win_init[WIN_WORDS-1] = LEN_WORD;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          w_adv = 1'b1;
          if (r_t == T_EMIT_LAST) w_state_nxt = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (out_ready) begin
          w_shift = 1'b1;
          if (r_t == T_LAST) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load || w_done) r_t <= '0;
      else if (w_adv)       r_t <= r_t + 6'd1;
    end
  end

  // The window only moves during expansion; EMIT reads the loaded block by index.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_win <= '0;
    end else if (w_load) begin
      r_win <= w_win_init;
    end else if (w_shift) begin
      r_win <= {w_next_word, r_win[WIN_WORDS-1:1]};
    end
  end

  always_comb begin
    w_out = '0;
    unique case (r_state)
      ST_EMIT:   w_out = r_win[r_t[3:0]];
      ST_EXPAND: w_out = w_next_word;
      default:   w_out = '0;
    endcase
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state != ST_IDLE);
  assign busy      = out_valid;
  assign t_out     = r_t;
  assign last      = out_valid && (r_t == T_LAST);

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
// Directed bench for sha256_w_sched_ctrl: hand constants plus a 64-entry
// reference schedule built independently from the padded block.
module tb_sha256_w_sched_ctrl;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready, last, busy;
  logic [255:0] digest_in;
  logic [31:0]  w_out;
  logic [5:0]   t_out;

  logic         l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_last, l_busy;
  logic [255:0] l_digest;
  logic [31:0]  l_w;
  logic [5:0]   l_t;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [31:0]  exp_w [64];
  logic [31:0]  got_w [64];

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_B =
    256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  always #5 CLK = ~CLK;

  sha256_w_sched_ctrl u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .digest_in (digest_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .w_out     (w_out),
    .t_out     (t_out),
    .last      (last),
    .busy      (busy)
  );

  sha256_w_sched_ctrl #(.LEN_WORD(32'h0000_0280)) u_dut_len (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (l_in_valid),
    .in_ready  (l_in_ready),
    .digest_in (l_digest),
    .out_valid (l_out_valid),
    .out_ready (l_out_ready),
    .w_out     (l_w),
    .t_out     (l_t),
    .last      (l_last),
    .busy      (l_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    ror = (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_ref(input logic [255:0] d, input logic [31:0] len);
    for (int i = 0; i < 8; i++) exp_w[i] = d[255-32*i -: 32];
    exp_w[8] = 32'h8000_0000;
    for (int i = 9; i < 15; i++) exp_w[i] = 32'h0;
    exp_w[15] = len;
    for (int t = 16; t < 64; t++)
      exp_w[t] = (ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
               + exp_w[t-7]
               + (ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
               + exp_w[t-16];
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " t_out"},     32'(t_out),     32'd0);
    check({tag, " w_out"},     w_out,          32'd0);
    check({tag, " last"},      32'(last),      32'd0);
  endtask

  // Called at a falling edge where the DUT is already presenting word 'first'.
  task automatic collect(input int first, input int nwords, input bit rnd, input string tag);
    int idx = first;
    int cyc = 0;
    while (idx < nwords && cyc < 1000) begin
      check($sformatf("%s t%0d out_valid", tag, idx), 32'(out_valid), 32'd1);
      check($sformatf("%s t%0d in_ready", tag, idx),  32'(in_ready),  32'd0);
      check($sformatf("%s t%0d t_out", tag, idx),     32'(t_out),     idx);
      check($sformatf("%s t%0d w_out", tag, idx),     w_out,          exp_w[idx]);
      check($sformatf("%s t%0d last", tag, idx),      32'(last),      32'(idx == 63));
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        got_w[idx] = w_out;
        idx++;
      end
      @(negedge CLK);
      cyc++;
    end
    check({tag, " handshake count"}, idx, nwords);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    digest_in   = '0;
    l_in_valid  = 1'b0;
    l_out_ready = 1'b0;
    l_digest    = '0;

    repeat (2) @(negedge CLK);
    check_idle("reset");
    RST = 1'b1;
    @(negedge CLK);
    check_idle("post-reset idle");

    // Zero digest, consumer always ready.
    build_ref('0, 32'h0000_0100);
    in_valid  = 1'b1;
    digest_in = '0;
    @(negedge CLK);
    in_valid = 1'b0;
    collect(0, 64, 1'b0, "zero");
    check_idle("zero end");
    check("zero W0",  got_w[0],  32'h0000_0000);
    check("zero W7",  got_w[7],  32'h0000_0000);
    check("zero W8",  got_w[8],  32'h8000_0000);
    check("zero W15", got_w[15], 32'h0000_0100);
    check("zero W16", got_w[16], 32'h0000_0000);
    check("zero W17", got_w[17], 32'h00A0_0000);

    // Digest of "abc" as the second-pass message.
    build_ref(ABC_DIGEST, 32'h0000_0100);
    in_valid  = 1'b1;
    digest_in = ABC_DIGEST;
    @(negedge CLK);
    in_valid = 1'b0;
    collect(0, 64, 1'b0, "abc");
    check_idle("abc end");
    check("abc W0", got_w[0], 32'hba78_16bf);
    check("abc W7", got_w[7], 32'hf200_15ad);

    // Random backpressure with a random digest.
    begin
      logic [255:0] rd;
      for (int i = 0; i < 8; i++) rd[32*i +: 32] = $urandom;
      build_ref(rd, 32'h0000_0100);
      in_valid  = 1'b1;
      digest_in = rd;
      @(negedge CLK);
      in_valid  = 1'b0;
      digest_in = '0;
      collect(0, 64, 1'b1, "stall");
      check_idle("stall end");
    end

    // in_valid held across two digests; digest_in changes mid-block.
    build_ref(ABC_DIGEST, 32'h0000_0100);
    in_valid  = 1'b1;
    digest_in = ABC_DIGEST;
    @(negedge CLK);
    digest_in = DIG_B;
    collect(0, 64, 1'b0, "held A");
    in_valid = 1'b1;
    check("held gap in_ready",  32'(in_ready),  32'd1);
    check("held gap out_valid", 32'(out_valid), 32'd0);
    @(negedge CLK);
    in_valid = 1'b0;
    build_ref(DIG_B, 32'h0000_0100);
    check("held B t_out", 32'(t_out), 32'd0);
    check("held B W0",    w_out,      32'h0123_4567);
    collect(0, 64, 1'b0, "held B");
    check_idle("held B end");

    // Asynchronous reset mid-block at t=30.
    build_ref(ABC_DIGEST, 32'h0000_0100);
    in_valid  = 1'b1;
    digest_in = ABC_DIGEST;
    @(negedge CLK);
    in_valid = 1'b0;
    collect(0, 30, 1'b0, "pre-rst");
    check("pre-rst t_out", 32'(t_out), 32'd30);
    RST = 1'b0;
    #1;
    check_idle("mid reset");
    @(negedge CLK);
    check("rst held out_valid", 32'(out_valid), 32'd0);
    RST       = 1'b1;
    in_valid  = 1'b1;
    digest_in = DIG_B;
    build_ref(DIG_B, 32'h0000_0100);
    @(negedge CLK);
    in_valid = 1'b0;
    check("post-rst W0", w_out, 32'h0123_4567);
    collect(0, 64, 1'b0, "post-rst");
    check_idle("post-rst end");

    // Overridden length word on the second instance.
    build_ref('0, 32'h0000_0280);
    l_in_valid = 1'b1;
    l_digest   = '0;
    @(negedge CLK);
    l_in_valid  = 1'b0;
    l_out_ready = 1'b1;
    for (int t = 0; t < 64; t++) begin
      check($sformatf("len t%0d valid", t), 32'(l_out_valid), 32'd1);
      check($sformatf("len t%0d t_out", t), 32'(l_t),         t);
      check($sformatf("len t%0d w_out", t), l_w,              exp_w[t]);
      check($sformatf("len t%0d last", t),  32'(l_last),      32'(t == 63));
      got_w[t] = l_w;
      @(negedge CLK);
    end
    l_out_ready = 1'b0;
    check("len W15",      got_w[15],          32'h0000_0280);
    check("len W17",      got_w[17],          32'h0110_0000);
    check("len end idle", 32'(l_out_valid),   32'd0);
    check("len end ready", 32'(l_in_ready),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sha256_w_sched_ctrl.md
SHA256_W_SCHED_CTRL -- requirements
Module: sha256_w_sched_ctrl

Interface
REQ-001 SHALL have parameter LEN_WORD, default 32'h00000100, giving the length word W15 of the padded block (256-bit digest).
REQ-002 SHALL have parameter PAD_WORD, default 32'h80000000, giving the padding word W8.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  digest_in holds a new 256-bit first-pass digest.
REQ-006 in_ready  output  1  block can accept a digest.
REQ-007 digest_in  input  256  digest; bits [255:224] are W0 and bits [31:0] are W7.
REQ-008 out_valid  output  1  w_out/t_out hold a valid schedule word.
REQ-009 out_ready  input  1  consumer accepts the word.
REQ-010 w_out  output  32  schedule word W[t].
REQ-011 t_out  output  6  index t of w_out, 0..63.
REQ-012 last  output  1  high with out_valid when t_out==63.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, EMIT and EXPAND.
REQ-015 IDLE: in_ready=1, out_valid=0; when in_valid=1, SHALL load window[0..15] = {digest words W0..W7, PAD_WORD, 6x32'h0, LEN_WORD}, set t=0 and go to EMIT.
REQ-016 Latency: W0 SHALL appear with out_valid=1 in the first cycle after the accepting edge.
REQ-017 EMIT (t<16): w_out=window[t]; on handshake (out_valid & out_ready), t<=t+1; on the handshake at t==15, go to EXPAND.
REQ-018 EXPAND (t>=16): w_out=W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16], computed combinationally from the 16-word window; addition is mod 2^32 and carries are discarded.
REQ-019 s0(x)=rotr7^rotr18^shr3, and s1(x)=rotr17^rotr19^shr10.
REQ-020 EXPAND handshake: the window SHALL shift by one word (oldest word dropped, W[t] appended) and t SHALL increment.
REQ-021 Handshake at t==63 with last=1: SHALL go to IDLE; in_ready SHALL be high in the next cycle, so back-to-back digests cost one idle cycle.
REQ-022 Backpressure: while out_valid=1 and out_ready=0, w_out, t_out, last and the window SHALL stay unchanged.
REQ-023 in_ready SHALL be 0 outside IDLE, and in_valid SHALL be ignored there.
REQ-024 out_valid SHALL be 1 in EMIT and EXPAND, and SHALL not drop until the t==63 handshake.
REQ-025 The t counter SHALL never wrap past 63; t==63 is the only exit from EXPAND.
REQ-026 t_out SHALL equal the internal t counter in all states, and SHALL be 0 in IDLE.

Reset
REQ-027 RST low SHALL, asynchronously: set state=IDLE, t=0, window=0, out_valid=0, last=0, busy=0, w_out=0 and t_out=0; in_ready SHALL become 1.
REQ-028 Reset mid-stream SHALL abandon the block with no further output, and a new digest SHALL be acceptable in the first cycle after release.

Structure
REQ-029 Shared package sha256_sched_pkg SHALL hold the state encoding, the PAD_WORD/LEN_WORD defaults and the s0/s1 functions.
REQ-030 The W[t] computation SHALL be one combinational sub-module, sha256_w_step (inputs: 16-word window; output: 32-bit word), reusable by other schedule stages.
REQ-031 All other registers, the FSM and the counter SHALL live in sha256_w_sched_ctrl; there are no memories and all storage is flops.

Verification
REQ-032 Zero digest with out_ready=1 -> W0..W7=0, W8=32'h80000000, W15=32'h00000100, W16=32'h0, W17=32'h00A00000, last only at t=63.
REQ-033 Digest from SHA-256 golden model (e.g., hash of "abc") -> all 64 words match the reference model word-for-word.
REQ-034 Random out_ready (50%) throughout -> values held stable during stalls, no word skipped or duplicated, 64 handshakes total.
REQ-035 in_valid held high across two digests -> second accepted exactly one cycle after the t=63 handshake, and in_ready=0 during the first block.
REQ-036 RST pulsed low at t=30 -> out_valid=0 immediately, then a fresh digest yields correct W0 in the first cycle after acceptance.
REQ-037 LEN_WORD overridden to 32'h00000280 -> W15=32'h00000280 and W17 matches the reference model.
